// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin sharing of one TRNG word assembler among several
// requesters. One fresh word is captured per grant and handed only to the
// granted client; a timeout returns an error if the entropy source stalls.
module rng_arbiter #(
  parameter int N_CLIENTS = 4,
  parameter int WIDTH     = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CLIENTS-1:0] cli_req,
  output logic [N_CLIENTS-1:0] cli_valid,
  output logic [N_CLIENTS-1:0] cli_err,
  output logic [WIDTH-1:0]     cli_word,
  output logic                 rng_req,
  input  logic                 rng_valid,
  input  logic [WIDTH-1:0]     rng_word,
  output logic                 busy
);

  localparam int GW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DELIVER,
    S_FAIL
  } state_t;

  state_t                 state_q;
  logic [GW-1:0]          rr_ptr_q;
  logic [GW-1:0]          grant_q;
  logic [WIDTH-1:0]       word_q;
  logic [TW-1:0]          timer_q;
  logic [N_CLIENTS-1:0]   cli_valid_q;
  logic [N_CLIENTS-1:0]   cli_err_q;
  logic                   busy_q;

  logic [GW-1:0]          grant_d;
  logic [GW-1:0]          rr_ptr_d;
  logic [GW-1:0]          scan_idx;
  logic                   found;
  logic [N_CLIENTS-1:0]   grant_oh;

  // Pick the first requesting client at or after rr_ptr, wrapping around.
  always_comb begin
    grant_d  = rr_ptr_q;
    found    = 1'b0;
    scan_idx = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      scan_idx = GW'((32'(rr_ptr_q) + i) % N_CLIENTS);
      if (!found && cli_req[scan_idx]) begin
        found   = 1'b1;
        grant_d = scan_idx;
      end
    end
  end

  // Pointer to the client after the current grant, and the grant as one-hot.
  always_comb begin
    if (grant_q == GW'(N_CLIENTS - 1)) begin
      rr_ptr_d = '0;
    end else begin
      rr_ptr_d = grant_q + 1'b1;
    end
    grant_oh = {{(N_CLIENTS-1){1'b0}}, 1'b1} << grant_q;
  end

  // Arbitration FSM with registered client-facing outputs.
  // word_q is only loaded on the WAIT->DELIVER edge and cleared on leaving
  // DELIVER, so it drives cli_word directly without leaking outside DELIVER.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      word_q      <= '0;
      timer_q     <= '0;
      cli_valid_q <= '0;
      cli_err_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|cli_req) begin
            grant_q <= grant_d;
            timer_q <= '0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rng_valid) begin
            word_q      <= rng_word;
            cli_valid_q <= grant_oh;
            state_q     <= S_DELIVER;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            cli_err_q <= grant_oh;
            state_q   <= S_FAIL;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        S_DELIVER: begin
          word_q      <= '0;
          cli_valid_q <= '0;
          rr_ptr_q    <= rr_ptr_d;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        S_FAIL: begin
          cli_err_q <= '0;
          rr_ptr_q  <= rr_ptr_d;
          busy_q    <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cli_valid = cli_valid_q;
  assign cli_err   = cli_err_q;
  assign cli_word  = word_q;
  assign busy      = busy_q;
  assign rng_req   = (state_q == S_WAIT);

endmodule
